// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester-side and memory-side signals of the shared byte-wide memory port
//   req_addr/req_wdata     : per-requester address/write data, slice i = [i*W +: W]
//   req_read_en/write_en   : per-requester request strobes
//   req_ready/req_rdata    : completion pulse (owner only) and shared read data
//   grant                  : one-hot current owner
//   mem_*                  : the single memory port
//   timeout_err            : sticky timeout flag
// master = arbiter, slave = requesters plus memory
interface mem_arbiter_if #(
    parameter int NREQ = 3,
    parameter int AW   = 32,
    parameter int DW   = 8
);
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    req_read_en;
    logic [NREQ-1:0]    req_write_en;
    logic [NREQ-1:0]    req_ready;
    logic [DW-1:0]      req_rdata;
    logic [NREQ-1:0]    grant;
    logic [AW-1:0]      mem_addr;
    logic [DW-1:0]      mem_data_in;
    logic               mem_read_en;
    logic               mem_write_en;
    logic               mem_ready;
    logic [DW-1:0]      mem_data_out;
    logic               timeout_err;
    modport master (
        input  req_addr, req_wdata, req_read_en, req_write_en, mem_ready, mem_data_out,
        output req_ready, req_rdata, grant, mem_addr, mem_data_in, mem_read_en, mem_write_en, timeout_err
    );
    modport slave (
        output req_addr, req_wdata, req_read_en, req_write_en, mem_ready, mem_data_out,
        input  req_ready, req_rdata, grant, mem_addr, mem_data_in, mem_read_en, mem_write_en, timeout_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory port between NREQ requesters
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : mem_arbiter_if.master -- requester handshakes in, memory port out,
//              one-hot grant, ready pulse, shared read data, sticky timeout_err
module mem_arbiter #(
    parameter int NREQ    = 3,
    parameter int AW      = 32,
    parameter int DW      = 8,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_DONE = 2'd1;
    localparam logic [1:0] RELEASE   = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] ready_q, ready_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            rd_q, rd_d;
    logic            wr_q, wr_d;
    logic            err_q, err_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [NREQ-1:0] active;
    logic            found;
    logic [IW-1:0]   win;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;
    logic            sel_wr;
    logic            timed_out;

    assign active    = bus.req_read_en | bus.req_write_en;
    // cnt_q counts completed WAIT_DONE cycles, so this fires at the end of cycle TIMEOUT
    assign timed_out = (TIMEOUT > 0) && (int'(cnt_q) + 1 >= TIMEOUT);

    // Round robin: lowest active index above rr_q, else wrap to lowest active overall.
    // Descending loops let the lowest matching index be the last assignment.
    always_comb begin
        found = 1'b0;
        win   = rr_q;
        for (int k = NREQ - 1; k >= 0; k--)
            if (active[k] && IW'(k) > rr_q) begin
                found = 1'b1;
                win   = IW'(k);
            end
        if (!found)
            for (int k = NREQ - 1; k >= 0; k--)
                if (active[k]) begin
                    found = 1'b1;
                    win   = IW'(k);
                end
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wr    = 1'b0;
        for (int k = 0; k < NREQ; k++)
            if (win == IW'(k)) begin
                sel_addr  = bus.req_addr[k*AW +: AW];
                sel_wdata = bus.req_wdata[k*DW +: DW];
                sel_wr    = bus.req_write_en[k];
            end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        ready_d = '0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE:
                if (found) begin
                    state_d = WAIT_DONE;
                    rr_d    = win;
                    grant_d = NREQ'(1) << win;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    wr_d    = sel_wr;
                    rd_d    = !sel_wr;
                    cnt_d   = '0;
                end
            WAIT_DONE:
                if (bus.mem_ready) begin
                    state_d = RELEASE;
                    ready_d = grant_q;
                    rdata_d = rd_q ? bus.mem_data_out : rdata_q;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                end else if (timed_out) begin
                    state_d = RELEASE;
                    ready_d = grant_q;
                    rdata_d = '1;
                    err_d   = 1'b1;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                end else
                    cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
            RELEASE:
                if (!bus.mem_ready) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk)
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= IW'(NREQ - 1);
            grant_q <= '0;
            ready_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            ready_q <= ready_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end

    assign bus.grant        = grant_q;
    assign bus.req_ready    = ready_q;
    assign bus.req_rdata    = rdata_q;
    assign bus.mem_addr     = addr_q;
    assign bus.mem_data_in  = wdata_q;
    assign bus.mem_read_en  = rd_q;
    assign bus.mem_write_en = wr_q;
    assign bus.timeout_err  = err_q;
endmodule
